// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM word/half/byte requests onto one byte-wide synchronous RAM port.
// MEM wins in IDLE; a granted access always runs to completion and ends with a single done cycle.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state_r;
    logic        sel_if_r;
    logic [2:0]  n_r;
    logic [2:0]  cnt_r;
    logic [31:0] wdata_r;
    logic [31:0] buf_r;
    logic [31:0] buf_next_s;
    logic [2:0]  n_s;
    logic [1:0]  rd_lane_s;
    logic [1:0]  wr_lane_s;

    // Decode MEM access length into a byte count.
    always_comb begin
        case (mem_len_i)
            2'b00:   n_s = 3'd1;
            2'b01:   n_s = 3'd2;
            default: n_s = 3'd4;
        endcase
    end

    // cnt_r counts RAM cycles already spent; the byte on ram_rdata_i belongs to lane cnt_r-1.
    always_comb begin
        rd_lane_s = cnt_r[1:0] - 2'd1;
        wr_lane_s = cnt_r[1:0] + 2'd1;
        if (cnt_r != 3'd0) begin
            buf_next_s = buf_r;
            buf_next_s[{rd_lane_s, 3'b000} +: 8] = ram_rdata_i;
        end else begin
            buf_next_s = buf_r;
        end
    end

    // Arbitration FSM with registered RAM-side and requester-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            sel_if_r    <= 1'b0;
            n_r         <= 3'd0;
            cnt_r       <= 3'd0;
            wdata_r     <= 32'd0;
            buf_r       <= 32'd0;
            if_rdata_o  <= 32'd0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= 32'd0;
            mem_done_o  <= 1'b0;
            ram_addr_o  <= {ADDR_W{1'b0}};
            ram_we_o    <= 1'b0;
            ram_wdata_o <= 8'd0;
            busy_o      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_req_i) begin
                        state_r     <= mem_we_i ? MEM_WR : MEM_RD;
                        sel_if_r    <= 1'b0;
                        n_r         <= n_s;
                        cnt_r       <= 3'd0;
                        buf_r       <= 32'd0;
                        wdata_r     <= mem_wdata_i;
                        ram_addr_o  <= mem_addr_i;
                        ram_we_o    <= mem_we_i;
                        ram_wdata_o <= mem_wdata_i[7:0];
                        busy_o      <= 1'b1;
                    end else if (if_req_i) begin
                        state_r    <= IF_RD;
                        sel_if_r   <= 1'b1;
                        n_r        <= 3'd4;
                        cnt_r      <= 3'd0;
                        buf_r      <= 32'd0;
                        ram_addr_o <= if_addr_i;
                        busy_o     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IF_RD, MEM_RD: begin
                    cnt_r <= cnt_r + 3'd1;
                    buf_r <= buf_next_s;
                    if (cnt_r < (n_r - 3'd1)) begin
                        ram_addr_o <= ram_addr_o + ADDR_INC;
                    end else begin
                        ram_addr_o <= ram_addr_o;
                    end
                    // One extra cycle after the last address collects the final byte.
                    if (cnt_r == n_r) begin
                        state_r <= DONE;
                        if (sel_if_r) begin
                            if_rdata_o <= buf_next_s;
                            if_done_o  <= 1'b1;
                        end else begin
                            mem_rdata_o <= buf_next_s;
                            mem_done_o  <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                MEM_WR: begin
                    if (cnt_r == (n_r - 3'd1)) begin
                        ram_we_o   <= 1'b0;
                        mem_done_o <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        cnt_r       <= cnt_r + 3'd1;
                        ram_addr_o  <= ram_addr_o + ADDR_INC;
                        ram_wdata_o <= wdata_r[{wr_lane_s, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    if_done_o  <= 1'b0;
                    mem_done_o <= 1'b0;
                    busy_o     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    if_done_o  <= 1'b0;
                    mem_done_o <= 1'b0;
                    ram_we_o   <= 1'b0;
                    busy_o     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a byte-array memory reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic [31:0] if_rdata_o;
    logic        if_done_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_len_i = 2'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] mem_wdata_i = 32'd0;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_wdata_o;
    logic [7:0]  ram_rdata_i = 8'd0;
    logic        busy_o;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // ram is the environment RAM the DUT drives; ref_mem is the model's view of memory.
    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] wr_addr_q [$];
    logic [7:0]  wr_byte_q [$];
    int          check_cnt = 0;
    int          error_cnt = 0;
    bit          in_wr = 1'b0;
    logic [31:0] exp_if_rd = 32'd0;
    logic [31:0] exp_mem_rd = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            error_cnt++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Synchronous RAM: data appears the cycle after its address, writes land on the edge.
    always @(posedge clk) begin
        ram_rdata_i <= ram[ram_addr_o[11:0]];
        if (ram_we_o) begin
            ram[ram_addr_o[11:0]] <= ram_wdata_o;
            wr_addr_q.push_back(ram_addr_o);
            wr_byte_q.push_back(ram_wdata_o);
        end
    end

    // Write strobe must only appear inside a busy write transaction.
    always @(negedge clk) begin
        if (ram_we_o) begin
            check_val("we_busy", {31'd0, busy_o}, 32'd1);
            check_val("we_in_wr", {31'd0, in_wr}, 32'd1);
        end
    end

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem[a[11:0]];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a[11:0]] = d;
        ref_mem[a[11:0]] = d;
    endtask

    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int lat;
        bit seen;
        logic [31:0] exp;
        logic [31:0] a;
        n = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
        exp = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            exp[8*k +: 8] = ref_rd(a);
        end
        wr_addr_q.delete();
        wr_byte_q.delete();
        in_wr = we && !is_if;
        @(posedge clk); #1;
        if (is_if) begin
            if_req_i = 1'b1; if_addr_i = addr;
        end else begin
            mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wdata;
        end
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            check_val("busy_active", {31'd0, busy_o}, 32'd1);
            check_val("no_wrong_done", {31'd0, (is_if ? mem_done_o : if_done_o)}, 32'd0);
            seen = is_if ? if_done_o : mem_done_o;
        end
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        check_val(is_if ? "if_latency" : (we ? "wr_latency" : "rd_latency"), lat,
                  (we && !is_if) ? n + 1 : n + 2);
        if (is_if) exp_if_rd = exp;
        else if (!we) exp_mem_rd = exp;
        check_val("if_rdata", if_rdata_o, exp_if_rd);
        check_val("mem_rdata", mem_rdata_o, exp_mem_rd);
        if (we && !is_if) begin
            check_val("wr_count", wr_addr_q.size(), n);
            for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
                a = addr + k;
                check_val("wr_addr", wr_addr_q[k], a);
                check_val("wr_byte", {24'd0, wr_byte_q[k]}, {24'd0, wdata[8*k +: 8]});
                ref_mem[a[11:0]] = wdata[8*k +: 8];
            end
        end else begin
            check_val("rd_no_write", wr_addr_q.size(), 0);
        end
        in_wr = 1'b0;
        @(posedge clk); #1;
        check_val("idle_busy", {31'd0, busy_o}, 32'd0);
        check_val("idle_done", {30'd0, if_done_o, mem_done_o}, 32'd0);
        check_val("idle_we", {31'd0, ram_we_o}, 32'd0);
        check_val("hold_if_rdata", if_rdata_o, exp_if_rd);
        check_val("hold_mem_rdata", mem_rdata_o, exp_mem_rd);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [31:0] exp;
        logic [31:0] a;
        logic [31:0] addr;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        #2;
        check_val("rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("rst_we", {31'd0, ram_we_o}, 32'd0);
        check_val("rst_addr", ram_addr_o, 32'd0);
        check_val("rst_rdata", if_rdata_o | mem_rdata_o, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Directed scenarios.
        preload(32'h100, 8'h13); preload(32'h101, 8'h00); preload(32'h102, 8'h00); preload(32'h103, 8'h93);
        run_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0);
        check_val("if_instr", if_rdata_o, 32'h93000013);
        run_txn(1'b0, 1'b1, 2'd2, 32'h200, 32'hDEADBEEF);
        preload(32'h301, 8'h80);
        run_txn(1'b0, 1'b0, 2'd0, 32'h301, 32'd0);
        check_val("byte_rd", mem_rdata_o, 32'h00000080);
        run_txn(1'b0, 1'b0, 2'd1, 32'h301, 32'd0);
        check_val("half_upper", {16'd0, mem_rdata_o[31:16]}, 32'd0);
        run_txn(1'b0, 1'b1, 2'd3, 32'hFFFFFFFE, 32'h44332211);
        run_txn(1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'd0);
        check_val("wrap_rdback", mem_rdata_o, 32'h44332211);

        // Simultaneous requests: MEM word read first, IF in the IDLE cycle after its done.
        exp = 32'd0;
        for (int k = 0; k < 4; k++) begin
            a = 32'h200 + k; exp[8*k +: 8] = ref_rd(a);
        end
        @(posedge clk); #1;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'd2; mem_addr_i = 32'h200;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1; lat++;
            check_val("sim_if_wait", {31'd0, if_done_o}, 32'd0);
            seen = mem_done_o;
        end
        mem_req_i = 1'b0;
        check_val("sim_mem_lat", lat, 6);
        check_val("sim_mem_data", mem_rdata_o, exp);
        exp_mem_rd = exp;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1; lat++;
            seen = if_done_o;
        end
        if_req_i = 1'b0;
        check_val("sim_if_lat", lat, 7);
        check_val("sim_if_data", if_rdata_o, 32'h93000013);
        exp_if_rd = 32'h93000013;
        @(posedge clk); #1;

        // Reset during the second byte of a word write.
        wr_addr_q.delete(); wr_byte_q.delete();
        in_wr = 1'b1;
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'd2; mem_addr_i = 32'h400; mem_wdata_i = 32'hA1B2C3D4;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_val("mid_rst_we", {31'd0, ram_we_o}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("mid_rst_addr", ram_addr_o, 32'd0);
        check_val("mid_rst_wdata", {24'd0, ram_wdata_o}, 32'd0);
        check_val("mid_rst_rdata", if_rdata_o | mem_rdata_o, 32'd0);
        check_val("mid_rst_wcount", wr_addr_q.size(), 1);
        ref_mem[12'h400] = 8'hD4;
        exp_if_rd = 32'd0; exp_mem_rd = 32'd0;
        mem_req_i = 1'b0; in_wr = 1'b0;
        #12 rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check_val("post_rst_done", {30'd0, if_done_o, mem_done_o}, 32'd0);
        end
        run_txn(1'b1, 1'b0, 2'd0, 32'h400, 32'd0);

        // Randomized traffic, with some accesses straddling the address wrap.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC + $urandom_range(0, 3);
            else addr = $urandom_range(0, 32'h3FF);
            run_txn(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), addr, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
